// File: rtl/f_d_reg.sv
// rtl/f_d_reg.sv - IF/ID pipeline register with stall, flush and exception bubble
// Optional FD_PERF_EN adds saturating stall and bubble event counters.
module f_d_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        req,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        f_ex_adel,
    input  logic        f_bd,
`ifdef FD_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt,
`endif
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exccode,
    output logic        d_bd,
    output logic        d_valid
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_pc      <= RESET_PC;
            d_instr   <= 32'd0;
            d_exccode <= 5'd0;
            d_bd      <= 1'b0;
            d_valid   <= 1'b0;
        end else if (req) begin
            d_pc      <= HANDLER_PC;
            d_instr   <= 32'd0;
            d_exccode <= 5'd0;
            d_bd      <= 1'b0;
            d_valid   <= 1'b0;
        end else if (stall) begin
            d_pc      <= d_pc;
            d_instr   <= d_instr;
            d_exccode <= d_exccode;
            d_bd      <= d_bd;
            d_valid   <= d_valid;
        end else if (flush) begin
            // PC and delay-slot flag survive so CP0 still reports the right EPC
            d_pc      <= f_pc;
            d_instr   <= 32'd0;
            d_exccode <= 5'd0;
            d_bd      <= f_bd;
            d_valid   <= 1'b0;
        end else begin
            d_pc      <= f_pc;
            d_instr   <= f_ex_adel ? 32'd0 : f_instr;
            d_exccode <= f_ex_adel ? EXC_ADEL : 5'd0;
            d_bd      <= f_bd;
            d_valid   <= 1'b1;
        end
    end

`ifdef FD_PERF_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = !req && stall;
    assign bubble_evt = req || (!stall && flush);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            if (stall_evt && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (bubble_evt && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_f_d_reg.sv
// tb/tb_f_d_reg.sv - scoreboard bench for f_d_reg
module tb_f_d_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        req = 1'b0;
    logic [31:0] f_pc = 32'd0;
    logic [31:0] f_instr = 32'd0;
    logic        f_ex_adel = 1'b0;
    logic        f_bd = 1'b0;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exccode;
    logic        d_bd;
    logic        d_valid;
`ifdef FD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    f_d_reg dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .req(req),
        .f_pc(f_pc),
        .f_instr(f_instr),
        .f_ex_adel(f_ex_adel),
        .f_bd(f_bd),
`ifdef FD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .d_pc(d_pc),
        .d_instr(d_instr),
        .d_exccode(d_exccode),
        .d_bd(d_bd),
        .d_valid(d_valid)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
        logic [31:0] stall_cnt;
        logic [31:0] bubble_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req_v);
        end
    endtask

    // Monitor: one registered result per edge, compared against the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check32("d_pc", d_pc, e.pc);
                check32("d_instr", d_instr, e.instr);
                check32("d_exccode", {27'd0, d_exccode}, {27'd0, e.exc});
                check32("d_bd", {31'd0, d_bd}, {31'd0, e.bd});
                check32("d_valid", {31'd0, d_valid}, {31'd0, e.valid});
`ifdef FD_PERF_EN
                check32("perf_stall_cnt", perf_stall_cnt, e.stall_cnt);
                check32("perf_bubble_cnt", perf_bubble_cnt, e.bubble_cnt);
`endif
            end
        end
    end

    task automatic step(input logic rst_n, input logic st, input logic fl, input logic rq,
                        input logic [31:0] pc, input logic [31:0] ins, input logic adel,
                        input logic bd, input exp_t e);
        @(negedge clk);
        reset = rst_n; stall = st; flush = fl; req = rq;
        f_pc = pc; f_instr = ins; f_ex_adel = adel; f_bd = bd;
        exp_q.push_back(e);
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] exc,
                                input logic bd, input logic v, input logic [31:0] sc,
                                input logic [31:0] bc);
        exp_t e;
        e.pc = pc; e.instr = ins; e.exc = exc; e.bd = bd; e.valid = v;
        e.stall_cnt = sc; e.bubble_cnt = bc;
        return e;
    endfunction

    initial begin
        int budget;
        // Reset held two edges with random side inputs
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                 1'($urandom), 1'($urandom), mk(32'h3000, 32'd0, 5'd0, 1'b0, 1'b0, 0, 0));
        step(1, 0, 0, 0, 32'h3004, 32'h3c01_1234, 0, 1, mk(32'h3004, 32'h3c01_1234, 5'd0, 1, 1, 0, 0));
        step(1, 0, 0, 0, 32'h3002, 32'hdead_beef, 1, 0, mk(32'h3002, 32'd0, 5'd4, 0, 1, 0, 0));
        step(1, 0, 0, 0, 32'h3008, 32'h8c22_0000, 0, 0, mk(32'h3008, 32'h8c22_0000, 5'd0, 0, 1, 0, 0));
        // Stall three edges, flush in the middle one must be ignored
        step(1, 1, 0, 0, 32'h300c, 32'h1111_1111, 0, 1, mk(32'h3008, 32'h8c22_0000, 5'd0, 0, 1, 1, 0));
        step(1, 1, 1, 0, 32'h3010, 32'h2222_2222, 1, 1, mk(32'h3008, 32'h8c22_0000, 5'd0, 0, 1, 2, 0));
        step(1, 1, 0, 0, 32'h3014, 32'h3333_3333, 0, 0, mk(32'h3008, 32'h8c22_0000, 5'd0, 0, 1, 3, 0));
        step(1, 0, 1, 0, 32'h3010, 32'h4444_4444, 0, 0, mk(32'h3010, 32'd0, 5'd0, 0, 0, 3, 1));
        step(1, 0, 0, 0, 32'h3014, 32'h2401_0001, 0, 0, mk(32'h3014, 32'h2401_0001, 5'd0, 0, 1, 3, 1));
        step(1, 0, 1, 0, 32'h3018, 32'h5555_5555, 0, 1, mk(32'h3018, 32'd0, 5'd0, 1, 0, 3, 2));
        step(1, 1, 0, 1, 32'h301c, 32'h6666_6666, 0, 1, mk(32'h4180, 32'd0, 5'd0, 0, 0, 3, 3));
        step(1, 0, 1, 0, 32'h3020, 32'h7777_7777, 1, 0, mk(32'h3020, 32'd0, 5'd0, 0, 0, 3, 4));
        step(1, 0, 0, 0, 32'h3024, 32'h1234_5678, 0, 0, mk(32'h3024, 32'h1234_5678, 5'd0, 0, 1, 3, 4));
        step(1, 1, 0, 0, 32'h3028, 32'h9999_9999, 0, 1, mk(32'h3024, 32'h1234_5678, 5'd0, 0, 1, 4, 4));
        // Reset during a stall aborts it
        step(0, 1, 0, 0, 32'h302c, 32'haaaa_aaaa, 0, 1, mk(32'h3000, 32'd0, 5'd0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 32'h3000, 32'h0000_0000, 0, 0, mk(32'h3000, 32'd0, 5'd0, 0, 1, 0, 0));

        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/f_d_reg.md
Name: f_d_reg

Overview:
IF/ID pipeline register between the PC/fetch stage and the decode stage. It captures the fetched PC, the instruction word, the fetch-address exception and the delay-slot flag every cycle. It supports stall (hold), flush (bubble) and exception request (load the handler-stage bubble). It is the single source of D-stage PC, instruction and exception code for the decoder and the CP0 path.

Parameters:
RESET_PC, 32'h0000_3000, d_pc value after reset
HANDLER_PC, 32'h0000_4180, d_pc value loaded on req
EXC_ADEL, 5'd4, exception code for fetch address error

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
stall  input  1  hold D-stage contents (hazard unit)
flush  input  1  replace incoming instruction with bubble (e.g. eret wrong-path kill)
req  input  1  exception/interrupt taken; clear stage to handler bubble
f_pc  input  32  PC of instruction in fetch stage
f_instr  input  32  instruction word from IM
f_ex_adel  input  1  fetch address error (misaligned or out of 0x3000..0x6fff)
f_bd  input  1  fetch instruction is in a branch delay slot
d_pc  output  32  D-stage PC
d_instr  output  32  D-stage instruction (0 = nop)
d_exccode  output  5  D-stage pending exception code, 0 = none
d_bd  output  1  D-stage delay-slot flag
d_valid  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (reset==0 at edge): d_pc=RESET_PC, d_instr=0, d_exccode=0, d_bd=0, d_valid=0. Reset overrides every other input and aborts any stall.
- Priority at each edge when reset==1: req > stall > flush > load.
- req=1: d_pc=HANDLER_PC, d_instr=0, d_exccode=0, d_bd=0, d_valid=0. This applies even when stall=1.
- stall=1 (req=0): all outputs hold. flush is ignored in that cycle; the hazard unit reasserts flush later if it is still needed.
- flush=1 (req=0, stall=0): d_pc=f_pc, d_instr=0, d_exccode=0, d_bd=f_bd, d_valid=0. The PC and delay-slot flag are kept so CP0 sees a correct macroscopic PC.
- Normal load: d_pc=f_pc, d_bd=f_bd, d_valid=1.
  - f_ex_adel=1: d_instr=0 (the fetched word is never decoded), d_exccode=EXC_ADEL.
  - f_ex_adel=0: d_instr=f_instr, d_exccode=0.
- Latency: exactly 1 cycle from F inputs to D outputs. No combinational path from any input to any output.
- Outputs are registers only. A stall held N cycles keeps outputs constant for N edges.

Optional Feature:
Macro FD_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt[31:0], which counts edges where reset==1, req==0 and stall==1. It saturates at 32'hFFFF_FFFF and resets to 0 on reset.
  - Adds output perf_bubble_cnt[31:0], which counts edges that load a bubble via flush or req. It saturates the same way and resets to 0.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs, then release -> d_pc=32'h3000, d_instr=0, d_exccode=0, d_valid=0.
- Normal load: f_pc=32'h3004, f_instr=32'h3c01_1234, f_bd=1 -> next edge d_pc=32'h3004, d_instr=32'h3c01_1234, d_bd=1, d_valid=1, d_exccode=0.
- AdEL: f_pc=32'h3002, f_ex_adel=1, f_instr=32'hdead_beef -> d_instr=0, d_exccode=4, d_pc=32'h3002, d_valid=1.
- Stall priority: load 32'h3008, then stall=1 for 3 cycles with f_pc changing and flush=1 in the 2nd cycle -> d_pc stays 32'h3008 and d_valid stays 1. After stall=0 the next F value loads.
- req over stall: stall=1 and req=1 at the same edge -> d_pc=32'h4180, d_instr=0, d_valid=0, d_bd=0.
- Flush plus perf: flush=1 with f_pc=32'h3010, f_bd=0 -> d_pc=32'h3010, d_instr=0, d_valid=0. With FD_PERF_EN, perf_bubble_cnt increments by 1, and the previous 3 stall cycles give perf_stall_cnt=3.
